// File: rtl/shift_reg_burst.sv
// General-purpose WIDTH-bit data/serialiser register with hold, load, shift, rotate and clear,
// plus a burst engine that repeats a latched shift/rotate step a programmed number of times.
module shift_reg_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] dout,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_dout;
   logic [CNT_W-1:0] r_remaining;
   logic [2:0]       r_mode;
   logic             r_dir;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_nx;
   logic [WIDTH-1:0] w_dout_nx;
   logic [CNT_W-1:0] w_remaining_nx;
   logic [2:0]       w_mode_nx;
   logic             w_dir_nx;
   logic             w_busy_nx;
   logic             w_done_nx;
   logic             w_burst_mode;

   // One register step for the given op; the reserved code behaves as hold.
   function automatic logic [WIDTH-1:0] f_step(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] data,
                                               input logic [WIDTH-1:0] load,
                                               input logic             ser);
      logic [WIDTH-1:0] res;
      case (op)
         MODE_HOLD: res = data;
         MODE_LOAD: res = load;
         MODE_SHL:  res = {data[WIDTH-2:0], ser};
         MODE_SHR:  res = {ser, data[WIDTH-1:1]};
         MODE_ROL:  res = {data[WIDTH-2:0], data[WIDTH-1]};
         MODE_ROR:  res = {data[0], data[WIDTH-1:1]};
         MODE_CLR:  res = {WIDTH{1'b0}};
         default:   res = data;
      endcase
      return res;
   endfunction

   // Serial-output direction: left ops expose the MSB, right ops the LSB.
   function automatic logic f_dir(input logic [2:0] op, input logic cur);
      logic res;
      case (op)
         MODE_SHL, MODE_ROL: res = 1'b0;
         MODE_SHR, MODE_ROR: res = 1'b1;
         default:            res = cur;
      endcase
      return res;
   endfunction

   assign w_burst_mode = (mode >= MODE_SHL) && (mode <= MODE_ROR);

   // Next-state, datapath and status logic.
   always_comb begin
      w_state_nx     = r_state;
      w_dout_nx      = r_dout;
      w_remaining_nx = r_remaining;
      w_mode_nx      = r_mode;
      w_dir_nx       = r_dir;
      w_busy_nx      = r_busy;
      w_done_nx      = 1'b0;
      if (en) begin
         case (r_state)
            ST_IDLE: begin
               if (start && w_burst_mode) begin
                  if (count != {CNT_W{1'b0}}) begin
                     w_state_nx     = ST_BUSY;
                     w_remaining_nx = count;
                     w_mode_nx      = mode;
                     w_busy_nx      = 1'b1;
                  end else begin
                     w_done_nx = 1'b1;
                  end
               end else begin
                  w_dout_nx = f_step(mode, r_dout, din, sin);
                  w_dir_nx  = f_dir(mode, r_dir);
               end
            end
            ST_BUSY: begin
               w_dout_nx      = f_step(r_mode, r_dout, din, sin);
               w_dir_nx       = f_dir(r_mode, r_dir);
               w_remaining_nx = r_remaining - CNT_W'(1);
               if (r_remaining == CNT_W'(1)) begin
                  w_state_nx = ST_IDLE;
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
               end else begin
                  w_state_nx = ST_BUSY;
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
               w_busy_nx  = 1'b0;
            end
         endcase
      end else begin
         w_done_nx = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_dout      <= {WIDTH{1'b0}};
         r_remaining <= {CNT_W{1'b0}};
         r_mode      <= MODE_HOLD;
         r_dir       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_dout      <= w_dout_nx;
         r_remaining <= w_remaining_nx;
         r_mode      <= w_mode_nx;
         r_dir       <= w_dir_nx;
         r_busy      <= w_busy_nx;
         r_done      <= w_done_nx;
      end
   end

   assign dout = r_dout;
   assign sout = r_dir ? r_dout[0] : r_dout[WIDTH-1];
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_shift_reg_burst.sv
// Directed-vector bench for shift_reg_burst (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_shift_reg_burst;

   logic       clock;
   logic       reset;
   logic       en;
   logic [2:0] mode;
   logic [7:0] din;
   logic       sin;
   logic       start;
   logic [3:0] count;
   logic [7:0] dout;
   logic       sout;
   logic       busy;
   logic       done;

   int checks;
   int failures;
   int bc;

   shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
      .clock(clock), .reset(reset), .en(en), .mode(mode), .din(din), .sin(sin),
      .start(start), .count(count), .dout(dout), .sout(sout), .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; en = 1'b0; mode = 3'b000; din = 8'h00; sin = 1'b0; start = 1'b0; count = 4'd0;
      tick(); tick();
      reset = 1'b0;
      check("rst_dout", dout, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);

      // async reset mid-cycle
      en = 1'b1; mode = 3'b001; din = 8'h5A; tick();
      check("pre_rst_load", dout, 8'h5A);
      mode = 3'b000; #2 reset = 1'b1; #1;
      check("async_rst_dout", dout, 8'h00);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_done", done, 1'b0);
      reset = 1'b0;
      tick(); tick(); tick();
      check("hold_zero", dout, 8'h00);

      // load and enable gating
      mode = 3'b001; din = 8'hA5; tick();
      check("load_a5", dout, 8'hA5);
      din = 8'h3C; en = 1'b0; tick();
      check("en_gate", dout, 8'hA5);
      mode = 3'b110; en = 1'b1; tick();
      check("clear", dout, 8'h00);

      // single steps
      mode = 3'b001; din = 8'h81; tick();
      check("load_81", dout, 8'h81);
      mode = 3'b100; tick();
      check("rol", dout, 8'h03);
      check("rol_sout", sout, 1'b0);
      mode = 3'b101; tick();
      check("ror", dout, 8'h81);
      check("ror_sout", sout, 1'b1);
      mode = 3'b010; sin = 1'b1; tick();
      check("shl", dout, 8'h03);
      mode = 3'b011; sin = 1'b0; tick();
      check("shr", dout, 8'h01);
      check("shr_sout", sout, 1'b1);

      // burst rotate left x3
      mode = 3'b001; din = 8'h01; tick();
      start = 1'b1; mode = 3'b100; count = 4'd3; tick();
      check("burst_busy_start", busy, 1'b1);
      check("burst_no_op", dout, 8'h01);
      start = 1'b0; mode = 3'b000;
      bc = 0;
      while (busy && bc < 20) begin tick(); bc++; end
      check("burst_busy_cycles", bc, 3);
      check("burst_dout", dout, 8'h08);
      check("burst_done", done, 1'b1);
      tick();
      check("burst_done_pulse", done, 1'b0);

      // burst rotate left x3 with a 2-cycle stall
      mode = 3'b001; din = 8'h01; tick();
      start = 1'b1; mode = 3'b100; count = 4'd3; tick();
      start = 1'b0; mode = 3'b000;
      bc = 0;
      while (busy && bc < 20) begin
         en = (bc == 1 || bc == 2) ? 1'b0 : 1'b1;
         tick(); bc++;
      end
      check("stall_busy_cycles", bc, 5);
      check("stall_dout", dout, 8'h08);
      check("stall_done", done, 1'b1);
      en = 1'b0; tick();
      check("done_clears_en0", done, 1'b0);
      en = 1'b1;

      // count = 0
      mode = 3'b001; din = 8'h5A; tick();
      start = 1'b1; mode = 3'b100; count = 4'd0; tick();
      check("cnt0_busy", busy, 1'b0);
      check("cnt0_done", done, 1'b1);
      check("cnt0_dout", dout, 8'h5A);
      start = 1'b0; mode = 3'b000; tick();
      check("cnt0_done_once", done, 1'b0);
      check("cnt0_dout_hold", dout, 8'h5A);

      // count = 9 rotate right on 0x01 wraps
      mode = 3'b001; din = 8'h01; tick();
      start = 1'b1; mode = 3'b101; count = 4'd9; tick();
      start = 1'b0; mode = 3'b000;
      bc = 0;
      while (busy && bc < 30) begin tick(); bc++; end
      check("cnt9_cycles", bc, 9);
      check("cnt9_dout", dout, 8'h80);
      check("cnt9_sout", sout, 1'b0);

      // start with non-burst mode acts as a load
      start = 1'b1; mode = 3'b001; din = 8'hC3; count = 4'd4; tick();
      check("start_load_dout", dout, 8'hC3);
      check("start_load_busy", busy, 1'b0);
      check("start_load_done", done, 1'b0);
      start = 1'b0;

      // start during BUSY ignored; restart in the done cycle
      mode = 3'b001; din = 8'h01; tick();
      start = 1'b1; mode = 3'b100; count = 4'd2; tick();
      mode = 3'b001; din = 8'hFF; count = 4'd5; tick();
      check("ign_step1", dout, 8'h02);
      check("ign_busy", busy, 1'b1);
      tick();
      check("ign_dout", dout, 8'h04);
      check("ign_done", done, 1'b1);
      check("ign_idle", busy, 1'b0);
      mode = 3'b100; count = 4'd1; tick();
      check("restart_busy", busy, 1'b1);
      check("restart_no_op", dout, 8'h04);
      start = 1'b0; mode = 3'b000; tick();
      check("restart_dout", dout, 8'h08);
      check("restart_done", done, 1'b1);

      // reset mid-burst
      mode = 3'b001; din = 8'hFF; tick();
      sin = 1'b0; start = 1'b1; mode = 3'b010; count = 4'd6; tick();
      start = 1'b0; mode = 3'b000;
      tick(); tick();
      check("mid_burst_dout", dout, 8'hFC);
      #2 reset = 1'b1; #1;
      check("mid_rst_dout", dout, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick();
      check("mid_rst_no_done", done, 1'b0);
      check("mid_rst_idle", busy, 1'b0);
      mode = 3'b001; din = 8'h66; tick();
      check("post_rst_load", dout, 8'h66);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_reg_burst.md
Name: shift_reg_burst

Overview:
- Parametrised successor to the single-bit enabled, async-reset D flip-flop.
- WIDTH-bit register with clock enable and asynchronous reset.
- Supports hold, parallel load, shift left/right, rotate left/right and synchronous clear.
- Adds a burst engine that performs a programmed number of shift/rotate steps with busy/done status. Used as the general-purpose data/serialiser register in datapath blocks.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- CNT_W, 4, width of the burst step-count input; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- en  input  1  clock enable; gates every register update except reset.
- mode  input  3  operation select (see Behaviour).
- din  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for shift modes.
- start  input  1  burst request, sampled when idle and en=1.
- count  input  CNT_W  burst step count, sampled with start.
- dout  output  WIDTH  register contents.
- sout  output  1  serial output bit (combinational from dout).
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after burst completion.

Behaviour:
- Reset (async, any time, including mid-burst): dout=0, busy=0, done=0, state=IDLE, remaining=0, latched mode=000, direction flag dir=0. Reset has priority over everything.
- Mode encoding:
  - 000 hold
  - 001 load din
  - 010 shift left: dout <= {dout[W-2:0], sin}
  - 011 shift right: dout <= {sin, dout[W-1:1]}
  - 100 rotate left
  - 101 rotate right
  - 110 clear to 0
  - 111 hold (reserved)
- en=0: no state, counter or register changes; done still deasserts the cycle after it was pulsed.
- sout = dout[W-1] when dir=0, dout[0] when dir=1.
  - dir is set to 0 by any 010/100 step and to 1 by any 011/101 step.
  - dir is unchanged by other modes.
- States: IDLE, BUSY.
- IDLE, en=1, start=0: single-step. The mode op is applied at the edge; 1-cycle latency to dout.
- IDLE, en=1, start=1, mode in 010..101, count>0:
  - No op is applied this cycle.
  - Latch mode and count into remaining; go to BUSY; busy=1 from the next cycle.
- IDLE, en=1, start=1, mode in 010..101, count=0: no op, stay IDLE, done=1 for the next cycle only.
- IDLE, start=1, mode not in 010..101: start is ignored and treated as a single-step of that mode.
- BUSY, each edge with en=1:
  - Apply the latched op; sin is sampled at each step.
  - remaining <= remaining-1.
  - If remaining==1: go to IDLE, busy=0 and done=1 for exactly one cycle.
- BUSY, en=0: stall; hold everything.
- BUSY: start, mode, count and din are ignored.
- Total busy-high cycles = count when en is held high; dout after the burst equals count successive single steps.
- count > WIDTH is legal: shifts saturate to the sin stream, rotates wrap modulo WIDTH.
- A new start is accepted in the same cycle done is high; that start re-enters BUSY.

Test Plan:
- Reset/hold: assert reset mid-cycle → dout=0x00, busy=0, done=0 immediately (asynchronously). Release reset, then mode=000 with en=1 for 3 cycles → dout stays 0x00.
- Load and enable gating: mode=001, din=0xA5, en=1 → dout=0xA5 next edge. Then din=0x3C with en=0 → dout stays 0xA5. Then mode=110, en=1 → dout=0x00.
- Single steps: load 0x81.
  - rotate left → 0x03, sout=0.
  - rotate right → 0x81, sout=1 (dir=1).
  - shift left with sin=1 → 0x03.
  - shift right with sin=0 → 0x01.
- Burst rotate: load 0x01, start=1, mode=100, count=3 → busy high for exactly 3 cycles, dout=0x08, done pulses 1 cycle while busy=0. Repeat with en low for 2 cycles mid-burst → busy high 5 cycles, same final dout.
- Burst edge cases:
  - count=0 → dout unchanged, busy never high, done pulses once.
  - count=9 rotate-right on 0x01 → dout=0x80.
  - start with mode=001 → acts as a load, no busy.
  - start asserted during BUSY → ignored.
- Reset mid-burst: load 0xFF, start a shift-left burst with count=6 and sin=0, assert reset after 2 steps → dout=0x00, busy=0, no done pulse. After release, a single-step works normally.
